branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Parametrised branch history/target table that drives the datapath's `prediction_bit` and `BHT_pc` inputs; the current top ties these to constants.
- Fetch-stage lookup is combinational: PC in, taken/not-taken prediction and predicted target out.
- The execute stage writes resolved branch outcomes back one update per cycle.
- Adds tagged entries, N-bit saturating counters, allocate-on-taken, global invalidate and saturating performance counters.

Parameters:
- PC_WIDTH, 32, width of PC and target addresses.
- ENTRIES, 64, table depth; power of 2, ≥4; IDX = log2(ENTRIES).
- CTR_BITS, 2, counter width; 1 gives a last-outcome predictor; legal range 1..4.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- lookup_valid  in  1  fetch lookup this cycle.
- lookup_pc  in  PC_WIDTH  fetch PC.
- prediction_bit  out  1  predict taken.
- BHT_pc  out  PC_WIDTH  predicted target; 0 when prediction_bit = 0.
- lookup_hit  out  1  valid entry with matching tag.
- upd_valid  in  1  resolved branch update.
- upd_pc  in  PC_WIDTH  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_WIDTH  actual target.
- upd_mispredict  in  1  datapath flagged a misprediction.
- flush_all  in  1  synchronous invalidate of all entries.
- lookup_count  out  CNT_WIDTH  number of lookups with lookup_valid = 1.
- mispredict_count  out  CNT_WIDTH  number of updates with upd_mispredict = 1.

Behaviour:
- Addressing:
  - Index = pc[IDX+1:2].
  - Tag = pc[PC_WIDTH-1:IDX+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag, ctr[CTR_BITS-1:0], target[PC_WIDTH-1:0].
- Reset (reset = 0, asynchronous):
  - All valid bits, counters and both perf counters clear to 0.
  - Outputs are therefore 0/0/0 and counts are 0.
  - Tags and targets need no reset.
  - Reset asserted mid-update discards that update.
- Lookup (combinational, zero latency):
  - lookup_hit = valid & tag match.
  - prediction_bit = lookup_hit & ctr[MSB] & lookup_valid.
  - BHT_pc = prediction_bit ? target : 0.
- Update (registered, visible from the cycle after the upd_valid edge):
  - Hit: saturating increment if taken, decrement if not taken. The counter saturates at 2^CTR_BITS-1 and at 0, with no wrap. On a taken hit, target is overwritten with upd_target.
  - Miss, taken: allocate (overwrite) the entry. Set valid = 1, tag, target = upd_target, ctr = 2^(CTR_BITS-1), i.e. weakly taken.
  - Miss, not taken: no change; not-taken branches are never allocated.
- Same-cycle lookup and update to the same index: lookup returns the pre-update state, with no bypass.
- flush_all:
  - Clears all valid bits on the next edge.
  - Has priority over an update in the same cycle, so that update is dropped.
  - Perf counters are unaffected.
- Perf counters:
  - lookup_count increments on each cycle with lookup_valid = 1.
  - mispredict_count increments on each upd_valid & upd_mispredict.
  - Both saturate at 2^CNT_WIDTH-1 and are cleared only by reset.
- No stall or handshake: updates are accepted every cycle; the caller guarantees at most one update per cycle.
- Expected size ~150–250 lines of RTL: counter array, tag/target array, saturating update logic, perf counters.

Test Plan (defaults: IDX = 6, tag = pc[31:8]):
- Reset: hold reset = 0 and apply lookup_pc = 0x40 with lookup_valid = 1 -> prediction_bit = 0, lookup_hit = 0, BHT_pc = 0, both counts = 0. Release reset and check lookup_count increments by 1 per cycle.
- Allocate/predict: update pc = 0x40, taken, target = 0x100 -> next cycle a lookup of 0x40 gives hit = 1, prediction_bit = 1 (ctr = 2), BHT_pc = 0x100.
  - An update with pc = 0x40, not taken, then gives ctr = 1 and prediction_bit = 0 with hit = 1.
- Saturation: apply 5 taken updates to 0x40 -> ctr stays 3. Then apply 2 not-taken updates -> ctr = 1, predict not taken. Then 3 more not-taken updates -> ctr = 0, with no wrap to 3.
- Aliasing: allocate 0x40 (target 0x100), then a taken update of 0x140 (same index, tag 1, target 0x200).
  - A lookup of 0x40 now misses.
  - A lookup of 0x140 predicts 0x200.
  - A not-taken update to miss pc 0x240 leaves the 0x140 entry intact.
- Simultaneous events:
  - Lookup of 0x40 in the same cycle as its allocating update -> that cycle shows hit = 0; the next cycle shows hit = 1.
  - flush_all together with an update -> all entries invalid and the update is dropped.
- Counter saturation and mode:
  - With CNT_WIDTH = 4, hold lookup_valid = 1 for 20 cycles -> lookup_count = 15.
  - 3 mispredict updates -> mispredict_count = 3.
  - With CTR_BITS = 1: taken gives predict taken and not taken gives predict not taken immediately.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Branch history/target table. The fetch-stage lookup is combinational.
// Execute-stage outcomes update the tagged saturating-counter entries, and perf counters track activity.
module branch_target_predictor #(
    parameter int PC_WIDTH  = 32,
    parameter int ENTRIES   = 64,
    parameter int CTR_BITS  = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 lookup_valid,
    input  logic [PC_WIDTH-1:0]  lookup_pc,
    output logic                 prediction_bit,
    output logic [PC_WIDTH-1:0]  BHT_pc,
    output logic                 lookup_hit,
    input  logic                 upd_valid,
    input  logic [PC_WIDTH-1:0]  upd_pc,
    input  logic                 upd_taken,
    input  logic [PC_WIDTH-1:0]  upd_target,
    input  logic                 upd_mispredict,
    input  logic                 flush_all,
    output logic [CNT_WIDTH-1:0] lookup_count,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX - 2;

    localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0]  CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    logic                valid_q  [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];

    logic [IDX-1:0]      lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic [IDX-1:0]      upd_idx;
    logic [TAG_W-1:0]    upd_tag;
    logic                upd_hit;
    logic                upd_write;
    logic                upd_alloc;
    logic [CTR_BITS-1:0] ctr_next;

    // Instruction alignment bits carry no branch identity.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx  = lookup_pc[IDX+1:2];
    assign lk_tag  = lookup_pc[PC_WIDTH-1:IDX+2];
    assign upd_idx = upd_pc[IDX+1:2];
    assign upd_tag = upd_pc[PC_WIDTH-1:IDX+2];

    // Lookup reads the table state held before this cycle's update; there is no bypass.
    assign lookup_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign prediction_bit = lookup_valid && lookup_hit && ctr_q[lk_idx][CTR_BITS-1];
    assign BHT_pc         = prediction_bit ? target_q[lk_idx] : '0;

    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_write = upd_valid && !flush_all && (upd_hit || upd_taken);
    assign upd_alloc = upd_valid && !flush_all && upd_taken;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ctr_next = ctr_q[upd_idx];
        if (upd_hit) begin
            if (upd_taken) begin
                if (ctr_q[upd_idx] != CTR_MAX) ctr_next = ctr_q[upd_idx] + CTR_BITS'(1);
            end else begin
                if (ctr_q[upd_idx] != '0) ctr_next = ctr_q[upd_idx] - CTR_BITS'(1);
            end
        end else if (upd_taken) begin
            ctr_next = CTR_WEAK;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= '0;
            end
        end else if (flush_all) begin
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
        end else if (upd_write) begin
            valid_q[upd_idx] <= 1'b1;
            ctr_q[upd_idx]   <= ctr_next;
        end
    end

    // NOTE: tag and target storage is deliberately not reset; an entry is meaningless until its valid bit is set.
    always_ff @(posedge clock) begin
        if (upd_alloc) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lookup_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (lookup_valid && lookup_count != CNT_MAX)
                lookup_count <= lookup_count + CNT_WIDTH'(1);
            if (upd_valid && upd_mispredict && mispredict_count != CNT_MAX)
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench: default-parameter instance plus a CNT_WIDTH=4 / CTR_BITS=1 instance.
module tb_branch_target_predictor;

    logic        clock = 1'b0;
    logic        reset;

    logic        lookup_valid, upd_valid, upd_taken, upd_mispredict, flush_all;
    logic [31:0] lookup_pc, upd_pc, upd_target;
    logic        prediction_bit, lookup_hit;
    logic [31:0] BHT_pc;
    logic [15:0] lookup_count, mispredict_count;

    logic        b_lookup_valid, b_upd_valid, b_upd_taken, b_upd_mispredict, b_flush_all;
    logic [31:0] b_lookup_pc, b_upd_pc, b_upd_target;
    logic        b_prediction_bit, b_lookup_hit;
    logic [31:0] b_BHT_pc;
    logic [3:0]  b_lookup_count, b_mispredict_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_lk = '0;

    always #5 clock = ~clock;

    branch_target_predictor dut_a (
        .clock(clock), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .prediction_bit(prediction_bit), .BHT_pc(BHT_pc), .lookup_hit(lookup_hit),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .flush_all(flush_all),
        .lookup_count(lookup_count), .mispredict_count(mispredict_count)
    );

    branch_target_predictor #(.CTR_BITS(1), .CNT_WIDTH(4)) dut_b (
        .clock(clock), .reset(reset),
        .lookup_valid(b_lookup_valid), .lookup_pc(b_lookup_pc),
        .prediction_bit(b_prediction_bit), .BHT_pc(b_BHT_pc), .lookup_hit(b_lookup_hit),
        .upd_valid(b_upd_valid), .upd_pc(b_upd_pc), .upd_taken(b_upd_taken),
        .upd_target(b_upd_target), .upd_mispredict(b_upd_mispredict),
        .flush_all(b_flush_all),
        .lookup_count(b_lookup_count), .mispredict_count(b_mispredict_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advances one edge; tracks the expected saturating lookup count of dut_a.
    task automatic tick();
        @(posedge clock);
        if (reset && lookup_valid && exp_lk != 16'hFFFF) exp_lk++;
        #1;
    endtask

    task automatic do_upd(input logic [31:0] pc, input logic taken,
                          input logic [31:0] target, input logic misp);
        upd_valid = 1'b1; upd_pc = pc; upd_taken = taken;
        upd_target = target; upd_mispredict = misp;
        tick();
        upd_valid = 1'b0; upd_mispredict = 1'b0;
        #1;
    endtask

    task automatic b_upd(input logic [31:0] pc, input logic taken, input logic [31:0] target);
        b_upd_valid = 1'b1; b_upd_pc = pc; b_upd_taken = taken; b_upd_target = target;
        tick();
        b_upd_valid = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        lookup_valid = 1'b1; lookup_pc = 32'h40;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_mispredict = 1'b0; flush_all = 1'b0;
        b_lookup_valid = 1'b0; b_lookup_pc = '0;
        b_upd_valid = 1'b0; b_upd_pc = '0; b_upd_taken = 1'b0; b_upd_target = '0;
        b_upd_mispredict = 1'b0; b_flush_all = 1'b0;

        // Reset held with an active lookup.
        #2;
        check("rst_pred", prediction_bit, 0);
        check("rst_hit", lookup_hit, 0);
        check("rst_bht", BHT_pc, 0);
        tick(); tick();
        check("rst_lk_count", lookup_count, 0);
        check("rst_mp_count", mispredict_count, 0);
        check("rst_b_lk_count", b_lookup_count, 0);
        reset = 1'b1;
        tick();
        check("lk_count_1", lookup_count, 1);
        tick();
        check("lk_count_2", lookup_count, 2);

        // Allocate with a same-cycle lookup: old state first, new entry next cycle.
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
        #1;
        check("same_cycle_hit", lookup_hit, 0);
        tick();
        upd_valid = 1'b0;
        #1;
        check("alloc_hit", lookup_hit, 1);
        check("alloc_pred", prediction_bit, 1);
        check("alloc_bht", BHT_pc, 32'h100);

        do_upd(32'h40, 1'b0, 32'h0, 1'b0);              // ctr 2 -> 1
        check("nt_hit", lookup_hit, 1);
        check("nt_pred", prediction_bit, 0);
        check("nt_bht", BHT_pc, 0);

        // Saturation at the top: 1->2->3->3->3->3, last update retargets.
        for (int i = 0; i < 4; i++) do_upd(32'h40, 1'b1, 32'h100, 1'b0);
        do_upd(32'h40, 1'b1, 32'h180, 1'b0);
        check("sat_hi_pred", prediction_bit, 1);
        check("retarget_bht", BHT_pc, 32'h180);
        do_upd(32'h40, 1'b0, 32'h0, 1'b0);              // 3 -> 2
        check("sat_hi_nt1_pred", prediction_bit, 1);
        do_upd(32'h40, 1'b0, 32'h0, 1'b0);              // 2 -> 1
        check("sat_hi_nt2_pred", prediction_bit, 0);
        check("sat_hi_nt2_hit", lookup_hit, 1);
        for (int i = 0; i < 3; i++) do_upd(32'h40, 1'b0, 32'h0, 1'b0);  // -> 0
        check("sat_lo_pred", prediction_bit, 0);
        do_upd(32'h40, 1'b1, 32'h180, 1'b0);            // 0 -> 1, not wrapped
        check("no_wrap_pred", prediction_bit, 0);
        do_upd(32'h40, 1'b1, 32'h180, 1'b0);            // 1 -> 2
        check("recover_pred", prediction_bit, 1);

        // Aliasing on index 16: tag 0 replaced by tag 1.
        do_upd(32'h140, 1'b1, 32'h200, 1'b0);
        lookup_pc = 32'h40; #1;
        check("alias_old_hit", lookup_hit, 0);
        check("alias_old_pred", prediction_bit, 0);
        check("alias_old_bht", BHT_pc, 0);
        lookup_pc = 32'h140; #1;
        check("alias_new_hit", lookup_hit, 1);
        check("alias_new_pred", prediction_bit, 1);
        check("alias_new_bht", BHT_pc, 32'h200);
        do_upd(32'h240, 1'b0, 32'h999, 1'b0);
        check("nt_miss_keep_hit", lookup_hit, 1);
        check("nt_miss_keep_bht", BHT_pc, 32'h200);
        lookup_pc = 32'h240; #1;
        check("nt_miss_no_alloc", lookup_hit, 0);
        lookup_valid = 1'b0; lookup_pc = 32'h140; #1;
        check("gate_pred", prediction_bit, 0);
        check("gate_hit", lookup_hit, 1);
        check("gate_bht", BHT_pc, 0);
        lookup_valid = 1'b1;

        // Flush beats a simultaneous allocating update.
        do_upd(32'h44, 1'b1, 32'h300, 1'b0);
        lookup_pc = 32'h44; #1;
        check("idx1_bht", BHT_pc, 32'h300);
        flush_all = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1; upd_target = 32'h400;
        tick();
        flush_all = 1'b0; upd_valid = 1'b0;
        #1;
        check("flush_idx1_hit", lookup_hit, 0);
        lookup_pc = 32'h140; #1;
        check("flush_idx16_hit", lookup_hit, 0);
        lookup_pc = 32'h80; #1;
        check("flush_drop_upd_hit", lookup_hit, 0);
        do_upd(32'h80, 1'b1, 32'h400, 1'b0);
        check("post_flush_bht", BHT_pc, 32'h400);

        // Mispredict counting; the flag alone without upd_valid does not count.
        upd_mispredict = 1'b1;
        tick();
        upd_mispredict = 1'b0;
        for (int i = 0; i < 3; i++) do_upd(32'h80, 1'b0, 32'h0, 1'b1);
        check("mp_count_3", mispredict_count, 3);
        check("lk_count_model", lookup_count, exp_lk);

        // Narrow instance: 4-bit lookup counter saturates at 15.
        b_lookup_valid = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check("b_lk_count_14", b_lookup_count, 14);
        for (int i = 0; i < 6; i++) tick();
        check("b_lk_count_sat", b_lookup_count, 15);

        // One-bit counter acts as a last-outcome predictor.
        b_lookup_pc = 32'h40;
        b_upd(32'h40, 1'b1, 32'h500);
        check("b_alloc_pred", b_prediction_bit, 1);
        check("b_alloc_bht", b_BHT_pc, 32'h500);
        b_upd(32'h40, 1'b0, 32'h0);
        check("b_nt_pred", b_prediction_bit, 0);
        check("b_nt_hit", b_lookup_hit, 1);
        b_upd(32'h40, 1'b1, 32'h500);
        check("b_t_pred", b_prediction_bit, 1);
        check("b_lk_count_hold", b_lookup_count, 15);
        check("b_mp_count", b_mispredict_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
